// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port 0)
// and the keyboard/input capture engine (port 1). One access at a time is
// walked through IDLE -> ISSUE -> RESP, with round-robin priority between the
// two ports when both ask in the same cycle.
//
// Handshake: a requester raises req together with stable we/addr/wdata and
// holds all of them until it sees its one-cycle ack. The arbiter latches the
// request at grant, so changes before ack are ignored. A port whose ack is
// high in the current cycle is not eligible for a new grant, so a requester
// may keep req high (or re-raise it) across the ack cycle without causing a
// duplicate access. rdata is valid in the cycle the ack is high and only
// changes on read completions.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          owner,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        state_q;
    logic          prio_q;
    logic          owner_q;
    logic          we_q;
    logic          p0_ack_q;
    logic          p1_ack_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;
    logic          mem_we_q;
    logic          busy_q;

    logic          elig0;
    logic          elig1;
    logic          grant_any_d;
    logic          grant_port_d;
    logic          grant_we_d;
    logic [AW-1:0] grant_addr_d;
    logic [DW-1:0] grant_wdata_d;

    // Pick the port to grant if the sequencer is idle this cycle.
    always_comb begin
        elig0         = p0_req & ~p0_ack_q;
        elig1         = p1_req & ~p1_ack_q;
        grant_any_d   = elig0 | elig1;
        grant_port_d  = (elig0 & elig1) ? prio_q : elig1;
        grant_we_d    = grant_port_d ? p1_we    : p0_we;
        grant_addr_d  = grant_port_d ? p1_addr  : p0_addr;
        grant_wdata_d = grant_port_d ? p1_wdata : p0_wdata;
    end

    // Access sequencer; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Acks are single-cycle pulses.
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        owner_q    <= grant_port_d;
                        we_q       <= grant_we_d;
                        mem_addr_q <= grant_addr_d;
                        mem_din_q  <= grant_wdata_d;
                        mem_we_q   <= grant_we_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The write commits at this edge; address stays put so
                    // the registered read data lines up in RESP.
                    mem_we_q <= 1'b0;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    if (owner_q) begin
                        p1_ack_q <= 1'b1;
                    end else begin
                        p0_ack_q <= 1'b1;
                    end
                    if (!we_q) begin
                        rdata_q <= mem_dout;
                    end
                    prio_q  <= ~owner_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a memory model behind the arbiter, a timing-level
// reference model compared every cycle, and directed scenarios with
// hand-computed expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_ack, p1_ack;
  logic [7:0] rdata, mem_addr, mem_din, mem_dout;
  logic       mem_we, busy, owner;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int we_cnt = 0;
  int ack0_cnt = 0;
  logic [7:0] last_waddr, last_wdin;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];

  // expected outputs from the reference model
  logic       e_ack0, e_ack1, e_we, e_busy, e_owner;
  logic [7:0] e_rdata, e_addr, e_din;

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  // ---------------- data memory (registered read) ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h30] = 8'h77;
    mem_dout = '0;
    forever begin
      @(posedge clk);
      mem_dout <= mem[mem_addr];
      if (mem_we === 1'b1) mem[mem_addr] = mem_din;
    end
  end

  // activity monitors, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        we_cnt++;
        last_waddr = mem_addr;
        last_wdin  = mem_din;
      end
      if (p0_ack === 1'b1) ack0_cnt++;
    end
  end

  // ---------------- reference model ----------------
  // Timing model: a grant at edge g puts the access on the memory pins
  // until g+1 (write commits there), and the ack/rdata appear after g+2.
  initial begin
    int  cyc, g;
    bit  act, prio, mp, mwe, el0, el1;
    logic [7:0] maddr, mwdata;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    exp_mem[8'h30] = 8'h77;
    act = 0; prio = 0; cyc = 0; g = 0; mp = 0; mwe = 0; maddr = 0; mwdata = 0;
    e_ack0 = 0; e_ack1 = 0; e_we = 0; e_busy = 0; e_owner = 0;
    e_rdata = 0; e_addr = 0; e_din = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        act = 0; prio = 0; cyc = 0;
        e_ack0 = 0; e_ack1 = 0; e_we = 0; e_busy = 0; e_owner = 0;
        e_rdata = 0; e_addr = 0; e_din = 0;
      end else begin
        cyc++;
        el0 = p0_req && !e_ack0;
        el1 = p1_req && !e_ack1;
        e_ack0 = 0;
        e_ack1 = 0;
        if (act) begin
          if (cyc == g + 1) begin
            if (mwe) exp_mem[maddr] = mwdata;
            e_we = 0;
          end else if (cyc == g + 2) begin
            if (mp) e_ack1 = 1; else e_ack0 = 1;
            if (!mwe) e_rdata = exp_mem[maddr];
            prio = !mp;
            act = 0;
            e_busy = 0;
          end
        end else if (el0 || el1) begin
          mp     = (el0 && el1) ? prio : el1;
          mwe    = mp ? p1_we : p0_we;
          maddr  = mp ? p1_addr : p0_addr;
          mwdata = mp ? p1_wdata : p0_wdata;
          g = cyc;
          act = 1;
          e_addr = maddr; e_din = mwdata; e_we = mwe;
          e_owner = mp; e_busy = 1;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cmp_p0_ack", 32'(p0_ack), 32'(e_ack0));
      check("cmp_p1_ack", 32'(p1_ack), 32'(e_ack1));
      check("cmp_rdata", 32'(rdata), 32'(e_rdata));
      check("cmp_mem_addr", 32'(mem_addr), 32'(e_addr));
      check("cmp_mem_din", 32'(mem_din), 32'(e_din));
      check("cmp_mem_we", 32'(mem_we), 32'(e_we));
      check("cmp_busy", 32'(busy), 32'(e_busy));
      check("cmp_owner", 32'(owner), 32'(e_owner));
      check("cmp_one_ack", 32'(p0_ack & p1_ack), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [7:0] a, input logic [7:0] d);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end
  endtask

  // wait (bounded) for the port's ack; returns the edge number or -1
  task automatic wait_ack(input bit port, input string name, output int ack_edge);
    bit got = 0;
    ack_edge = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        got = 1;
        ack_edge = edge_cnt;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no ack expected ack within 20 cycles", name);
    end
  endtask

  task automatic do_access(input bit port, input bit we, input logic [7:0] a,
                           input logic [7:0] d, input string name,
                           output int ack_edge, output int lat,
                           output logic [7:0] rd, output logic own);
    int start;
    @(negedge clk);
    drive(port, 1, we, a, d);
    start = edge_cnt;
    wait_ack(port, name, ack_edge);
    lat = ack_edge - start;
    rd  = rdata;
    own = owner;
    @(negedge clk);
    drive(port, 0, 0, 8'h00, 8'h00);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int ae0, ae1, lat0, lat1, wc0, ac0, a_edge, b_edge;
    logic [7:0] rd0, rd1;
    logic own0, own1;
    int order_q[$];

    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_acks", 32'({p0_ack, p1_ack}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // single CPU write then read
    wc0 = we_cnt;
    do_access(0, 1, 8'h10, 8'hA5, "wr10", ae0, lat0, rd0, own0);
    check("wr10_latency", 32'(lat0), 32'd3);
    check("wr10_we_cycles", 32'(we_cnt - wc0), 32'd1);
    check("wr10_addr", 32'(last_waddr), 32'h10);
    check("wr10_din", 32'(last_wdin), 32'hA5);
    do_access(0, 0, 8'h10, 8'h00, "rd10", ae0, lat0, rd0, own0);
    check("rd10_latency", 32'(lat0), 32'd3);
    check("rd10_rdata", 32'(rd0), 32'hA5);
    check("rd10_no_write", 32'(we_cnt - wc0), 32'd1);

    // contention straight after reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fork
      do_access(0, 0, 8'h20, 8'h00, "cont_p0", ae0, lat0, rd0, own0);
      do_access(1, 1, 8'h21, 8'h3C, "cont_p1", ae1, lat1, rd1, own1);
    join
    check("cont_p0_latency", 32'(lat0), 32'd3);
    check("cont_ack_gap", 32'(ae1 - ae0), 32'd3);
    check("cont_owner0", 32'(own0), 32'd0);
    check("cont_owner1", 32'(own1), 32'd1);
    check("cont_rdata", 32'(rd0), 32'h7A);
    check("cont_mem21", 32'(mem[8'h21]), 32'h3C);

    // fairness: both held for 12 cycles
    @(negedge clk);
    drive(0, 1, 0, 8'h40, 8'h00);
    drive(1, 1, 0, 8'h41, 8'h00);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (p0_ack === 1'b1) order_q.push_back(0);
      if (p1_ack === 1'b1) order_q.push_back(1);
    end
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    check("fair_ack_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < order_q.size() && i < 4; i++)
      check("fair_order", 32'(order_q[i]), 32'(i % 2));
    repeat (2) @(negedge clk);

    // p1 keeps req high across its ack, then asks for a second write
    wc0 = we_cnt;
    @(negedge clk);
    drive(1, 1, 1, 8'h50, 8'h11);
    wait_ack(1, "rereq_first", a_edge);
    check("rereq_busy_in_ack", 32'(busy), 32'd0);
    check("rereq_we_in_ack", 32'(mem_we), 32'd0);
    @(negedge clk);
    drive(1, 1, 1, 8'h51, 8'h22);
    wait_ack(1, "rereq_second", b_edge);
    @(negedge clk);
    drive(1, 0, 0, 8'h00, 8'h00);
    check("rereq_ack_gap", 32'(b_edge - a_edge), 32'd4);
    check("rereq_we_cycles", 32'(we_cnt - wc0), 32'd2);
    check("rereq_mem50", 32'(mem[8'h50]), 32'h11);
    check("rereq_mem51", 32'(mem[8'h51]), 32'h22);

    // a write leaves rdata alone
    do_access(0, 0, 8'h30, 8'h00, "rd30", ae0, lat0, rd0, own0);
    check("rd30_rdata", 32'(rd0), 32'h77);
    do_access(1, 1, 8'h31, 8'h12, "wr31", ae1, lat1, rd1, own1);
    check("wr31_rdata_kept", 32'(rd1), 32'h77);
    check("wr31_mem31", 32'(mem[8'h31]), 32'h12);

    // reset during ISSUE of a write
    ac0 = ack0_cnt;
    @(negedge clk);
    drive(0, 1, 1, 8'h05, 8'hFF);
    @(posedge clk);
    #2;
    check("rst_issue_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_we", 32'(mem_we), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_rdata", 32'(rdata), 32'd0);
    check("rst_async_ack", 32'(p0_ack), 32'd0);
    check("rst_async_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mem05", 32'(mem[8'h05]), 32'h5F);
    check("rst_no_ack", 32'(ack0_cnt - ac0), 32'd0);

    // retry after reset release
    do_access(0, 0, 8'h05, 8'h00, "retry05", ae0, lat0, rd0, own0);
    check("retry05_rdata", 32'(rd0), 32'h5F);
    check("retry05_latency", 32'(lat0), 32'd3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port 8-bit data memory between the CPU (port 0) and the keyboard/input capture engine (port 1). Each request is held until a one-cycle acknowledge. The block serialises accesses through a three-state sequencer and uses round-robin priority. It sits between both requesters and the data memory's address, data-in, write-enable and data-out pins inside the MCU top level.

## Interface
- AW, 8, memory address width
- DW, 8, memory data width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  CPU access request; held high until p0_ack
- p0_we  in  1  CPU access type: 1 = write, 0 = read
- p0_addr  in  AW  CPU address
- p0_wdata  in  DW  CPU write data
- p0_ack  out  1  one-cycle completion pulse to CPU
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack  —  identical set for the keyboard/input engine
- rdata  out  DW  read data; valid in the cycle p0_ack or p1_ack is high
- mem_addr  out  AW  to data memory address
- mem_din  out  DW  to data memory write data
- mem_we  out  1  to data memory write enable
- mem_dout  in  DW  from data memory; registered read, valid one cycle after mem_addr
- busy  out  1  high whenever state ≠ IDLE
- owner  out  1  port index of the current/most recent grant

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - A port is eligible if its req = 1 and its ack is not high in this cycle. This lets a requester drop or re-raise req on the ack cycle without a duplicate access.
  - If no port is eligible, stay in IDLE.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port named by priority pointer prio.
  - On grant: latch that port's we, addr and wdata into internal registers; set owner; go to ISSUE.
- ISSUE: drive mem_addr, mem_din and mem_we from the latched registers for exactly one cycle, then go to RESP.
- RESP:
  - mem_we = 0 and mem_addr is held.
  - On the exiting edge: pulse the owner's ack; load rdata from mem_dout (reads only; writes leave rdata unchanged); set prio to the non-owner port; return to IDLE.
- Requester rule: req, we, addr and wdata are held stable from assertion until ack. Changes before ack are ignored because the values are latched at grant.
- Only one ack is high in any cycle; p0_ack and p1_ack are never high together.
- Arithmetic: none; addresses are passed through unmodified, no wrap or offset.

## Timing
- Reset values: state = IDLE, prio = 0, owner = 0, p0_ack = p1_ack = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_din = 0, busy = 0.
- Latency: a request sampled at edge N produces ack high during cycle N+2 → N+3. Read data appears on rdata in that same cycle.
- Throughput: one access per 3 cycles sustained. With both ports requesting continuously, grants alternate 0,1,0,1.
- A write commits at the edge ending the ISSUE cycle.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately (asynchronously).
  - An access in ISSUE whose commit edge coincides with or follows reset assertion is not written.
  - An in-flight access is dropped with no ack; the requester must retry after reset release.
- Simultaneous first requests after reset: port 0 wins (prio = 0).
- A req arriving while busy waits; it is considered at the next IDLE.

## Test plan
- Single CPU write then read: p0 write addr 0x10 data 0xA5, then read 0x10 → mem_we high exactly one cycle with mem_addr = 0x10 and mem_din = 0xA5; second p0_ack carries rdata = 0xA5; each ack arrives 2 cycles after the request is sampled.
- Contention from reset: p0 reads 0x20 and p1 writes 0x21 = 0x3C, both raised at the same edge → p0_ack first, p1_ack 3 cycles later, owner = 0 then 1, memory[0x21] = 0x3C.
- Fairness: both req held high for 12 cycles → exactly 4 acks, ordered 0,1,0,1; never two acks in one cycle.
- Ack-cycle re-request: p1 keeps req high across its ack → no access is issued in the ack cycle; the next grant starts the following cycle, so no duplicate write.
- Reset mid-access: assert rst during ISSUE of a p0 write of 0xFF to 0x05 → mem_we drops immediately, memory[0x05] is unchanged, no p0_ack, busy = 0 and rdata = 0.
- Write preserves rdata: read 0x30 returning 0x77, then write 0x31 = 0x12 → rdata stays 0x77 through the write ack.
